uop_block_harness: RTL and testbench
====================================

// Module: uop_block_harness
// PURPOSE
//   Self-test driver/collector for the registered uop block datapath. Generates
//   pseudo-random src/shamt vectors from a Galois LFSR, issues one per cycle,
//   and compacts returned dst results into a MISR signature aligned by a fixed
//   round-trip latency. Used for BIST-style sign-off against a software model.
// PARAMETERS
//   W          64                  datapath width (src/dst), >= 2
//   LATENCY    3                   cycles from src_o change to matching dst_i, >= 1
//   N_VECTORS  256                 vectors issued per run, >= 1
//   POLY       64'hD800000000000000 Galois feedback poly (LFSR and MISR)
//   SEED       64'h1               LFSR start value, must be nonzero
// PORTS
//   clk          in   1                 clock, all state on posedge
//   rst          in   1                 synchronous, active-high reset
//   start_i      in   1                 begin run; honoured only in IDLE/DONE
//   src_o        out  W                 stimulus operand (current LFSR value)
//   shamt_o      out  $clog2(W)         stimulus shift amount = src_o[W-1 -: $clog2(W)]
//   issue_o      out  1                 src_o/shamt_o is a live vector this cycle
//   dst_i        in   W                 result from datapath under test
//   busy_o       out  1                 state is RUN or DRAIN
//   done_o       out  1                 state is DONE; signature_o final
//   signature_o  out  W                 MISR contents
//   vec_cnt_o    out  $clog2(N_VECTORS+1) vectors captured so far this run
// BEHAVIOUR
//   Reset: state=IDLE, lfsr=SEED, misr=0, counters=0, valid pipe=0; so
//     src_o=SEED, issue_o=0, busy_o=0, done_o=0, signature_o=0, vec_cnt_o=0.
//   Reset mid-run aborts immediately; no partial signature is held.
//   FSM: IDLE -start_i-> RUN -> DRAIN -> DONE -start_i-> RUN.
//   start_i sampled at edge ending cycle t (IDLE/DONE): lfsr<=SEED, misr<=0,
//     counters<=0, state<=RUN. start_i in RUN/DRAIN ignored.
//   RUN: issue_o=1; vector k (k=0..N-1) held on src_o in cycle t+1+k;
//     lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0) each RUN cycle; after vector
//     N-1 issued, state<=DRAIN (RUN lasts exactly N_VECTORS cycles).
//   Alignment: LATENCY-deep shift register of issue_o; capture when its tail=1,
//     i.e. dst_i in cycle c pairs with vector issued in cycle c-LATENCY.
//   Capture: misr <= (misr>>1) ^ (misr[0] ? POLY : 0) ^ dst_i; vec_cnt++.
//   Non-capture cycles: misr and vec_cnt hold; dst_i ignored (X-safe).
//   DRAIN: no issue; lfsr holds; exits to DONE on the edge that performs the
//     N_VECTORS-th capture. done_o first high in cycle t+1+N_VECTORS+LATENCY.
//   DONE: misr, vec_cnt, lfsr hold; done_o stays high until start_i or rst.
//   busy_o high cycles t+1 .. t+N_VECTORS+LATENCY inclusive.
//   Width rules: all XOR/shift mod 2^W; vec_cnt never exceeds N_VECTORS.
//   Elaboration error if LATENCY<1, N_VECTORS<1, or SEED==0.
// TESTING (W=8, POLY=8'hB8, SEED=8'h01, LATENCY=3, N_VECTORS=4 unless noted)
//   1 rst 2 cycles -> src_o=8'h01, issue/busy/done=0, signature_o=0, vec_cnt_o=0.
//   2 start_i at cycle 0 -> src_o 01,B8,5C,2E in cycles 1-4 with issue_o=1;
//     busy_o cycles 1-7; done_o from cycle 8; vec_cnt_o=4.
//   3 dst_i=0 always -> signature 8'h00; dst_i=8'h01 only in cycle 4 (first
//     capture), else 0 -> signature 8'h2E.
//   4 start_i pulsed in cycles 2 and 6 -> ignored; timing identical to test 2.
//   5 rst in cycle 5 -> cycle 6 matches reset state; new start runs cleanly.
//   6 bench loops src_o back via 3-cycle delay, W=64 defaults, N=256: signature
//     equals C model; rerun from DONE gives same value; one flipped bit differs.

Source files
------------

// File: rtl/uop_block_harness.sv
// uop_block_harness: self-test driver and collector for the registered uop
// datapath. A Galois LFSR produces one stimulus vector per cycle while running.
// Returned results are folded into a MISR. The fold is aligned to the fixed
// round-trip latency by a shift register that delays the issue flag.
module uop_block_harness #(
  parameter int unsigned    W         = 64,
  parameter int unsigned    LATENCY   = 3,
  parameter int unsigned    N_VECTORS = 256,
  parameter logic [W-1:0]   POLY      = 64'hD800000000000000,
  parameter logic [W-1:0]   SEED      = 64'h1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  output logic [W-1:0]                   src_o,
  output logic [$clog2(W)-1:0]           shamt_o,
  output logic                           issue_o,
  input  logic [W-1:0]                   dst_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [W-1:0]                   signature_o,
  output logic [$clog2(N_VECTORS+1)-1:0] vec_cnt_o
);

  localparam int unsigned    SW       = $clog2(W);
  localparam int unsigned    CW       = $clog2(N_VECTORS + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(N_VECTORS - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(N_VECTORS);
  localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

  // Reject parameter sets that cannot produce a meaningful run.
  if (LATENCY < 1) begin : g_bad_latency
    $error("uop_block_harness: LATENCY must be >= 1");
  end
  if (N_VECTORS < 1) begin : g_bad_nvec
    $error("uop_block_harness: N_VECTORS must be >= 1");
  end
  if (SEED == {W{1'b0}}) begin : g_bad_seed
    $error("uop_block_harness: SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       lfsr_q, lfsr_d;
  logic [W-1:0]       misr_q, misr_d;
  logic [CW-1:0]      vec_cnt_q, vec_cnt_d;
  logic [CW-1:0]      iss_cnt_q, iss_cnt_d;
  logic [LATENCY-1:0] valid_q, valid_d;
  logic               issue_s;
  logic               capture_s;

  // One Galois shift step; both the LFSR and the MISR share the same polynomial.
  function automatic logic [W-1:0] galois_step(input logic [W-1:0] v);
    galois_step = (v >> 1) ^ (v[0] ? POLY : {W{1'b0}});
  endfunction

  assign issue_s   = (state_q == S_RUN);
  // The oldest pipe stage marks the cycle in which dst_i belongs to an issued vector.
  assign capture_s = valid_q[LATENCY-1];

  // Delay line for the issue flag; its tail lines dst_i up with its vector.
  always_comb begin
    valid_d    = {LATENCY{1'b0}};
    valid_d[0] = issue_s;
    for (int i = 1; i < int'(LATENCY); i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  // Next-state, LFSR advance, and MISR compaction.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    vec_cnt_d = vec_cnt_q;
    iss_cnt_d = iss_cnt_q;

    // The count guard keeps a stray capture from ever pushing past N_VECTORS.
    if (capture_s && (vec_cnt_q != FULL_CNT)) begin
      misr_d    = galois_step(misr_q) ^ dst_i;
      vec_cnt_d = vec_cnt_q + ONE_CNT;
    end else begin
      misr_d    = misr_q;
      vec_cnt_d = vec_cnt_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RUN;
          lfsr_d    = SEED;
          misr_d    = {W{1'b0}};
          vec_cnt_d = {CW{1'b0}};
          iss_cnt_d = {CW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        lfsr_d    = galois_step(lfsr_q);
        iss_cnt_d = iss_cnt_q + ONE_CNT;
        if (iss_cnt_q == LAST_CNT) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (capture_s && (vec_cnt_q == LAST_CNT)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      misr_q    <= {W{1'b0}};
      vec_cnt_q <= {CW{1'b0}};
      iss_cnt_q <= {CW{1'b0}};
      valid_q   <= {LATENCY{1'b0}};
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      vec_cnt_q <= vec_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      valid_q   <= valid_d;
    end
  end

  assign src_o       = lfsr_q;
  assign shamt_o     = lfsr_q[W-1 -: SW];
  assign issue_o     = issue_s;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign signature_o = misr_q;
  assign vec_cnt_o   = vec_cnt_q;

endmodule

// File: tb/tb_uop_block_harness.sv
// Bench for uop_block_harness. A small instance (W=8, N=4) is checked every
// cycle against a model that derives all outputs from the cycle offset since
// the accepted start. A full-size instance is run with src_o looped back
// through a 3-cycle delay and compared with a software MISR signature.
module tb_uop_block_harness;

  localparam int S_L = 3;
  localparam int S_N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s;
  logic        a_start;
  logic [7:0]  a_dst;
  logic [7:0]  a_src;
  logic [2:0]  a_shamt;
  logic        a_issue, a_busy, a_done;
  logic [7:0]  a_sig;
  logic [2:0]  a_vc;

  logic        b_start;
  logic [63:0] b_dst;
  logic [63:0] b_src;
  logic [5:0]  b_shamt;
  logic        b_issue, b_busy, b_done;
  logic [63:0] b_sig;
  logic [8:0]  b_vc;
  logic [63:0] d0, d1, d2, flip_mask;

  uop_block_harness #(.W(8), .LATENCY(3), .N_VECTORS(4), .POLY(8'hB8), .SEED(8'h01)) u_small (
    .clk(clk), .rst(rst_s), .start_i(a_start), .src_o(a_src), .shamt_o(a_shamt),
    .issue_o(a_issue), .dst_i(a_dst), .busy_o(a_busy), .done_o(a_done),
    .signature_o(a_sig), .vec_cnt_o(a_vc)
  );

  uop_block_harness u_big (
    .clk(clk), .rst(rst_s), .start_i(b_start), .src_o(b_src), .shamt_o(b_shamt),
    .issue_o(b_issue), .dst_i(b_dst), .busy_o(b_busy), .done_o(b_done),
    .signature_o(b_sig), .vec_cnt_o(b_vc)
  );

  // Loopback for the big instance: dst in cycle c equals src from cycle c-3.
  always @(posedge clk) begin
    d0 <= b_src;
    d1 <= d0;
    d2 <= d1;
  end
  assign b_dst = d2 ^ flip_mask;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;
  bit m_run    = 1'b0;
  bit chk_en   = 1'b0;
  logic [7:0] msig = 8'h00;
  logic [7:0] lfsr_tab [0:4];
  logic [7:0] lit_src [1:4] = '{8'h01, 8'hB8, 8'h5C, 8'h2E};

  function automatic logic [7:0] step8(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [63:0] step64(input logic [63:0] v);
    return (v >> 1) ^ (v[0] ? 64'hD800000000000000 : 64'h0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepted starts, resets, and MISR folding at each edge.
  initial begin
    int rel;
    lfsr_tab[0] = 8'h01;
    for (int k = 1; k <= S_N; k++) lfsr_tab[k] = step8(lfsr_tab[k-1]);
    forever begin
      @(posedge clk);
      rel = cyc - t0;
      if (rst_s) begin
        m_run = 1'b0;
        msig  = 8'h00;
      end else begin
        if (m_run && rel >= S_L + 1 && rel <= S_L + S_N) msig = step8(msig) ^ a_dst;
        if (a_start && (!m_run || rel > S_L + S_N)) begin
          m_run = 1'b1;
          t0    = cyc;
          msig  = 8'h00;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of the small instance against the model.
  initial begin
    int rel, idx, vc;
    logic [7:0] e_src;
    logic e_iss, e_busy, e_done;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        rel = cyc - t0;
        if (!m_run) begin
          e_src = 8'h01; e_iss = 1'b0; e_busy = 1'b0; e_done = 1'b0; vc = 0;
        end else begin
          idx    = (rel - 1 > S_N) ? S_N : rel - 1;
          e_src  = lfsr_tab[idx];
          e_iss  = (rel <= S_N);
          e_busy = (rel <= S_N + S_L);
          e_done = (rel > S_N + S_L);
          vc     = rel - 1 - S_L;
          if (vc < 0) vc = 0;
          if (vc > S_N) vc = S_N;
        end
        check("m_src",   64'(a_src),   64'(e_src));
        check("m_shamt", 64'(a_shamt), 64'(e_src[7:5]));
        check("m_issue", 64'(a_issue), 64'(e_iss));
        check("m_busy",  64'(a_busy),  64'(e_busy));
        check("m_done",  64'(a_done),  64'(e_done));
        check("m_sig",   64'(a_sig),   64'(msig));
        check("m_vcnt",  64'(a_vc),    64'(vc));
      end
    end
  end

  // One small-instance run with hand-computed expectations per cycle offset.
  task automatic run_fixed(input logic [7:0] d4, input bit pulses, input logic [7:0] esig);
    a_start = 1'b1;
    a_dst   = 8'h00;
    tick();
    a_start = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      a_dst   = (r == 4) ? d4 : 8'h00;
      a_start = pulses && (r == 2 || r == 6);
      @(negedge clk);
      if (r <= 4) check("lit_src", 64'(a_src), 64'(lit_src[r]));
      check("lit_issue", 64'(a_issue), 64'(r <= 4));
      check("lit_busy",  64'(a_busy),  64'(r <= 7));
      check("lit_done",  64'(a_done),  64'(r >= 8));
      if (r == 9) begin
        check("lit_sig",  64'(a_sig), 64'(esig));
        check("lit_vcnt", 64'(a_vc),  64'd4);
      end
      tick();
    end
    a_start = 1'b0;
  endtask

  // Full-size run; flip_rel selects the cycle whose loopback gets a bit flipped.
  task automatic big_run(input int flip_rel);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int r = 1; r < 2000 && !b_done; r++) begin
      flip_mask = (r == flip_rel) ? 64'h80 : 64'h0;
      tick();
    end
    flip_mask = 64'h0;
    @(negedge clk);
    check("big_done", 64'(b_done), 64'd1);
  endtask

  initial begin
    logic [63:0] golden, v;
    rst_s = 1'b1; a_start = 1'b0; b_start = 1'b0; a_dst = 8'h00; flip_mask = 64'h0;
    tick();
    tick();
    rst_s  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_src",  64'(a_src),   64'h01);
    check("rst_flags", {61'd0, a_issue, a_busy, a_done}, 64'd0);
    check("rst_sig",  64'(a_sig),   64'h00);
    check("rst_vcnt", 64'(a_vc),    64'd0);
    tick();

    run_fixed(8'h00, 1'b0, 8'h00);
    run_fixed(8'h01, 1'b0, 8'h2E);
    run_fixed(8'h00, 1'b1, 8'h00);

    // Reset in the fifth cycle of a run, then a clean restart.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int r = 1; r < 5; r++) tick();
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    @(negedge clk);
    check("abort_src",   64'(a_src),  64'h01);
    check("abort_flags", {61'd0, a_issue, a_busy, a_done}, 64'd0);
    check("abort_sig",   64'(a_sig),  64'h00);
    check("abort_vcnt",  64'(a_vc),   64'd0);
    tick();
    run_fixed(8'h01, 1'b0, 8'h2E);

    // Random data, start pulses and occasional resets.
    for (int i = 0; i < 400; i++) begin
      a_dst   = 8'($urandom);
      a_start = ($urandom_range(0, 3) == 0);
      rst_s   = ($urandom_range(0, 149) == 0);
      tick();
    end
    a_start = 1'b0;
    rst_s   = 1'b0;
    tick();

    // Full-size loopback against a software MISR.
    golden = 64'h0;
    v      = 64'h1;
    for (int k = 0; k < 256; k++) begin
      golden = step64(golden) ^ v;
      v      = step64(v);
    end
    big_run(0);
    check("big_sig",   b_sig, golden);
    check("big_vcnt",  64'(b_vc), 64'd256);
    check("big_src",   b_src, v);
    check("big_shamt", 64'(b_shamt), 64'(v[63:58]));
    check("big_idle",  {62'd0, b_issue, b_busy}, 64'd0);
    big_run(0);
    check("big_rerun_sig", b_sig, golden);
    big_run(100);
    n_checks++;
    if (b_sig !== golden) n_pass++;
    else $display("FAIL big_flip: got %h expected a value differing from %h", b_sig, golden);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
